// File: rtl/ddr_rd_port.sv
// Read-side DDR front end: burst requests -> AXI4 AR, R beats -> credit-managed show-ahead FIFO -> ddr stream.
// Optional macro DDR_RD_LAST_CHK_EN adds per-burst rlast checking with a sticky err flag.
module ddr_rd_port #(
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 8,
  parameter int DDR_W      = 512,
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DDR_ADDR_W-1:0] req_addr,
  input  logic [BURST_W-1:0]    req_size,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [DDR_ADDR_W-1:0] m_araddr,
  output logic [BURST_W-1:0]    m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DDR_W-1:0]      m_rdata,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [DDR_W-1:0]      ddr_data,
  output logic                  ddr_valid,
  input  logic                  ddr_ready,
  output logic                  busy,
  output logic                  err
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // a source holds its payload stable while valid is high and ready is low.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = CW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic {IDLE, AR} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]    reserved_q;
  logic [OW-1:0]    outst_q;
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic [DDR_W-1:0] mem [FIFO_DEPTH];

  logic          empty, push, pop, accept, ar_fire, burst_end, outst_dec;
  logic          credit_ok, outst_ok;
  logic [NW-1:0] credit_need;
  logic [CW-1:0] add_v;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign m_rready  = rst;
  assign push      = m_rvalid & m_rready;
  assign ddr_valid = ~empty;
  assign ddr_data  = empty ? '0 : mem[rd_ptr_q[PW-1:0]];
  assign pop       = ddr_valid & ddr_ready;

  // Reserved counts FIFO entries plus beats still owed by the slave; a push just
  // moves a beat from owed to stored, so only accepts and pops change it.
  assign credit_need = NW'(reserved_q) + NW'(req_size) + NW'(1);
  assign credit_ok   = (credit_need <= NW'(FIFO_DEPTH));
  assign outst_ok    = (outst_q < OW'(MAX_OUTST));
  assign req_ready   = rst & (state_q == IDLE) & credit_ok & outst_ok;
  assign accept      = req_valid & req_ready;
  assign ar_fire     = m_arvalid & m_arready;
  assign add_v       = accept ? (CW'(req_size) + CW'(1)) : '0;
  assign outst_dec   = burst_end & (outst_q != '0);
  assign busy        = (state_q != IDLE) | (outst_q != '0) | ~empty;

  always_comb begin
    state_d   = state_q;
    m_arvalid = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = AR;
      AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      m_araddr   <= '0;
      m_arlen    <= '0;
      reserved_q <= '0;
      outst_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        m_araddr <= req_addr;
        m_arlen  <= req_size;
      end
      reserved_q <= reserved_q + add_v - CW'(pop);
      case ({ar_fire, outst_dec})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PW-1:0]] <= m_rdata;
  end

`ifdef DDR_RD_LAST_CHK_EN
  localparam int LW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [BURST_W-1:0] len_mem [MAX_OUTST];
  logic [LW-1:0]      lf_wr_q, lf_rd_q;
  logic [BURST_W-1:0] beat_cnt_q;
  logic               have_burst, exp_last, err_q;

  function automatic logic [LW-1:0] lf_next(input logic [LW-1:0] p);
    return (p == LW'(MAX_OUTST - 1)) ? '0 : p + LW'(1);
  endfunction

  // AXI returns bursts in order, so the oldest stored len describes the current burst.
  assign have_burst = (outst_q != '0);
  assign exp_last   = (beat_cnt_q == len_mem[lf_rd_q]);
  assign burst_end  = push & have_burst & (m_rlast | exp_last);
  assign err        = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lf_wr_q    <= '0;
      lf_rd_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (ar_fire) lf_wr_q <= lf_next(lf_wr_q);
      if (burst_end) begin
        lf_rd_q    <= lf_next(lf_rd_q);
        beat_cnt_q <= '0;
      end else if (push && have_burst) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (push && (!have_burst || (m_rlast != exp_last))) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_fire) len_mem[lf_wr_q] <= m_arlen;
  end
`else
  assign burst_end = push & m_rlast;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rd_port.sv
// Bench for ddr_rd_port: AXI slave model, request driver, and a negedge monitor that
// scoreboards AR, stream data, credit/outstanding limits, busy and err against a counter model.
module tb_ddr_rd_port;
  localparam int DDR_ADDR_W = 32;
  localparam int BURST_W    = 8;
  localparam int DDR_W      = 512;
  localparam int FIFO_DEPTH = 512;
  localparam int MAX_OUTST  = 4;
`ifdef DDR_RD_LAST_CHK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic                  clk, rst;
  logic [DDR_ADDR_W-1:0] req_addr, m_araddr;
  logic [BURST_W-1:0]    req_size, m_arlen;
  logic                  req_valid, req_ready, m_arvalid, m_arready;
  logic [DDR_W-1:0]      m_rdata, ddr_data;
  logic                  m_rlast, m_rvalid, m_rready, ddr_valid, ddr_ready, busy, err;

  ddr_rd_port #(
    .DDR_ADDR_W(DDR_ADDR_W), .BURST_W(BURST_W), .DDR_W(DDR_W),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_size(req_size), .req_valid(req_valid), .req_ready(req_ready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
    .busy(busy), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DDR_W-1:0]      exp_q[$];
  logic [DDR_ADDR_W-1:0] exp_addr_q[$];
  logic [BURST_W-1:0]    exp_len_q[$];
  int slv_len_q[$];
  int slv_beat = 0;
  int accepted_beats = 0, popped_beats = 0, pending_ar = 0, ar_hs = 0, rlast_cnt = 0;
  int acc_cnt = 0, pop_cnt = 0, rbeat_cnt = 0, cyc = 0;
  int first_pop_cyc = -1, last_pop_cyc = -1;
  int early_at = -1;
  logic exp_err = 1'b0;
  int ar_mode = 1, r_mode = 1, ds_mode = 1;  // 0 random, 1 always, 2 never

  task automatic check(input string name, input logic [DDR_W-1:0] act, input logic [DDR_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DDR_W-1:0] rand_beat();
    logic [DDR_W-1:0] v;
    for (int i = 0; i < DDR_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit pick(input int mode);
    return (mode == 1) || ((mode == 0) && ($urandom_range(0, 1) == 1));
  endfunction

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete(); exp_addr_q.delete(); exp_len_q.delete(); slv_len_q.delete();
      slv_beat = 0; accepted_beats = 0; popped_beats = 0; pending_ar = 0;
      ar_hs = 0; rlast_cnt = 0; exp_err = 1'b0;
    end else begin
      // Cycle-exact expectations derived from the transaction counts so far
      check("req_ready", req_ready,
            (pending_ar == 0) &&
            (accepted_beats - popped_beats + int'(req_size) + 1 <= FIFO_DEPTH) &&
            (ar_hs - rlast_cnt < MAX_OUTST));
      check("ar_valid", m_arvalid, pending_ar != 0);
      check("ddr_valid", ddr_valid, exp_q.size() != 0);
      check("busy", busy, (pending_ar != 0) || (ar_hs != rlast_cnt) || (exp_q.size() != 0));
      check("err", err, exp_err);

      if (ddr_valid && ddr_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", exp_q.size(), 1);
        else check("ddr_data", ddr_data, exp_q.pop_front());
        popped_beats++; pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      if (m_arvalid && m_arready) begin
        if (exp_addr_q.size() == 0) check("ar_unexpected", exp_addr_q.size(), 1);
        else begin
          check("ar_addr", m_araddr, exp_addr_q.pop_front());
          check("ar_len", m_arlen, exp_len_q.pop_front());
        end
        pending_ar--; ar_hs++;
        slv_len_q.push_back(int'(m_arlen));
      end
      if (req_valid && req_ready) begin
        exp_addr_q.push_back(req_addr);
        exp_len_q.push_back(req_size);
        accepted_beats += int'(req_size) + 1;
        pending_ar++; acc_cnt++;
      end
      if (m_rvalid && m_rready) begin
        exp_q.push_back(m_rdata);
        rbeat_cnt++;
        if (m_rlast) begin
          rlast_cnt++;
          if (slv_len_q.size() != 0 && slv_beat != slv_len_q[0]) exp_err = ERR_EXP;
          if (slv_len_q.size() != 0) void'(slv_len_q.pop_front());
          slv_beat = 0;
        end else begin
          slv_beat++;
        end
      end
    end
  end

  // ---------------- AXI slave + stream sink drivers ----------------
  initial begin
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; ddr_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      m_arready = pick(ar_mode);
      ddr_ready = pick(ds_mode);
      if (rst && slv_len_q.size() != 0 && pick(r_mode)) begin
        m_rvalid = 1'b1;
        m_rdata  = rand_beat();
        m_rlast  = (slv_beat == slv_len_q[0]) || (slv_beat == early_at);
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
      end
    end
  end

  // ---------------- request driver tasks ----------------
  task automatic req_start(input logic [DDR_ADDR_W-1:0] a, input logic [BURST_W-1:0] s);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_size = s;
  endtask

  task automatic req_wait(input int start, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != start) break;
    end
    req_valid = 1'b0;
    check("req_accept_timeout", acc_cnt != start, 1);
  endtask

  task automatic send_req(input logic [DDR_ADDR_W-1:0] a, input logic [BURST_W-1:0] s, input int budget);
    int start;
    start = acc_cnt;
    req_start(a, s);
    req_wait(start, budget);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && pending_ar == 0 && ar_hs == rlast_cnt && slv_len_q.size() == 0) break;
    end
    check("idle_timeout", i < budget, 1);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_reset_outs();
    check("rst_req_ready", req_ready, 0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_arlen", m_arlen, 0);
    check("rst_rready", m_rready, 0);
    check("rst_ddr_valid", ddr_valid, 0);
    check("rst_ddr_data", ddr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int base, ar_base, start;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outs();
    rst = 1'b1;

    // Single burst
    ar_mode = 1; r_mode = 1; ds_mode = 1;
    base = pop_cnt;
    send_req(32'h1000, 8'd3, 50);
    wait_idle(200);
    check("single_pops", pop_cnt - base, 4);

    // Credit boundary: two full-size bursts fill the FIFO exactly
    ds_mode = 2;
    base = rbeat_cnt;
    send_req(32'h0, 8'd255, 50);
    send_req(32'h2000, 8'd255, 50);
    for (int i = 0; i < 2000 && rbeat_cnt - base < 512; i++) @(posedge clk);
    check("credit_fill", rbeat_cnt - base, 512);
    start = acc_cnt;
    req_start(32'h3000, 8'd0);
    repeat (10) @(posedge clk);
    check("credit_block", acc_cnt - start, 0);
    #1 ds_mode = 1;
    @(posedge clk); #1 ds_mode = 2;
    req_wait(start, 20);
    ds_mode = 1;
    wait_idle(2000);

    // Outstanding limit with the R channel stalled
    r_mode = 2;
    ar_base = ar_hs;
    for (int i = 0; i < 4; i++) send_req(DDR_ADDR_W'(32'h4000 + i * 64), 8'd0, 50);
    start = acc_cnt;
    req_start(32'h5000, 8'd0);
    repeat (10) @(posedge clk);
    check("outst_ar_count", ar_hs - ar_base, 4);
    check("outst_block", acc_cnt - start, 0);
    #1 r_mode = 1;
    req_wait(start, 50);
    wait_idle(200);

    // Continuous stream: one beat per cycle with no gaps
    first_pop_cyc = -1;
    base = pop_cnt;
    send_req(32'h8000, 8'd31, 50);
    wait_idle(200);
    check("stream_pops", pop_cnt - base, 32);
    check("stream_gapless", last_pop_cyc - first_pop_cyc, 31);

    // Reset in the middle of a burst
    base = rbeat_cnt;
    send_req(32'h9000, 8'd7, 50);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rbeat_cnt - base >= 2) break;
    end
    rst = 1'b0;
    #1 check_reset_outs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    base = pop_cnt;
    send_req(32'h40, 8'd0, 50);
    wait_idle(200);
    check("post_reset_pops", pop_cnt - base, 1);

    // Randomized traffic
    ar_mode = 0; r_mode = 0; ds_mode = 0;
    for (int n = 0; n < 30; n++) begin
      send_req(DDR_ADDR_W'($urandom),
               ($urandom_range(0, 3) == 0) ? BURST_W'($urandom_range(0, 255))
                                           : BURST_W'($urandom_range(0, 15)), 3000);
    end
    wait_idle(20000);

    // Early rlast on the second beat of a 4-beat burst
    ar_mode = 1; r_mode = 1; ds_mode = 1;
    early_at = 1;
    send_req(32'hA000, 8'd3, 50);
    wait_idle(200);
    early_at = -1;
    repeat (5) @(posedge clk);
    #1 check("err_sticky", err, ERR_EXP);
    rst = 1'b0;
    #1 check("err_reset", err, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
